pcie_rx_req_decoder: RTL and testbench

//  Receive side of the 64-bit PCIe AXI-Stream user interface. Consumes m_axis_rx from the 7-series PCIe core.

---
 rtl/pcie_rx_req_decoder.sv | 122 ++++++++++++
 tb/tb_pcie_rx_req_decoder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_rx_req_decoder.sv
// pcie_rx_req_decoder: decodes single-DW MWr32/MRd32 TLPs hitting one BAR into register
// write strobes and read requests; every other TLP is consumed and counted as dropped.
module pcie_rx_req_decoder #(
    parameter int C_DATA_WIDTH = 64,
    parameter int KEEP_WIDTH   = C_DATA_WIDTH / 8,
    parameter int ADDR_WIDTH   = 10,
    parameter int BAR_NUM      = 0,
    parameter int TCQ          = 1
) (
    input  logic                    user_clk,
    input  logic                    user_reset,
    input  logic [C_DATA_WIDTH-1:0] m_axis_rx_tdata,
    input  logic [KEEP_WIDTH-1:0]   m_axis_rx_tkeep,
    input  logic                    m_axis_rx_tlast,
    input  logic                    m_axis_rx_tvalid,
    output logic                    m_axis_rx_tready,
    input  logic [21:0]             m_axis_rx_tuser,
    output logic                    rx_np_ok,
    output logic                    wr_en,
    output logic [ADDR_WIDTH-1:0]   wr_addr,
    output logic [31:0]             wr_data,
    output logic [3:0]              wr_be,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [15:0]             rd_req_id,
    output logic [7:0]              rd_tag,
    output logic [2:0]              rd_tc,
    output logic [1:0]              rd_attr,
    output logic [15:0]             drop_count
);
    typedef enum logic [1:0] {IDLE, HDR2, DISCARD, RD_WAIT} state_t;
    state_t      state;
    logic        is_wr;
    logic [15:0] req_id;
    logic [7:0]  tag;
    logic [2:0]  tc;
    logic [1:0]  attr;
    logic [3:0]  first_be;
    logic        beat;
    logic        hdr_ok;
    logic [15:0] drop_next;
    logic        unused_bits;

    assign m_axis_rx_tready = state != RD_WAIT;
    assign rx_np_ok         = state != RD_WAIT;
    assign beat             = m_axis_rx_tvalid && m_axis_rx_tready;
    assign drop_next        = drop_count + {15'd0, drop_count != 16'hFFFF};
    assign unused_bits      = ^{m_axis_rx_tkeep, m_axis_rx_tuser, m_axis_rx_tdata, TCQ != 0};

    // A header that ends on its first beat cannot carry an address, so it is dropped too
    assign hdr_ok = (m_axis_rx_tdata[30:24] == 7'h40 || m_axis_rx_tdata[30:24] == 7'h00) &&
                    m_axis_rx_tdata[9:0] == 10'd1 && !m_axis_rx_tdata[14] &&
                    !m_axis_rx_tuser[1] && m_axis_rx_tuser[2+BAR_NUM] && !m_axis_rx_tlast;

    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            state      <= IDLE;
            is_wr      <= 1'b0;
            req_id     <= '0;
            tag        <= '0;
            tc         <= '0;
            attr       <= '0;
            first_be   <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            wr_be      <= '0;
            rd_valid   <= 1'b0;
            rd_addr    <= '0;
            rd_req_id  <= '0;
            rd_tag     <= '0;
            rd_tc      <= '0;
            rd_attr    <= '0;
            drop_count <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                IDLE: if (beat) begin
                    is_wr    <= m_axis_rx_tdata[30];
                    tc       <= m_axis_rx_tdata[22:20];
                    attr     <= m_axis_rx_tdata[13:12];
                    req_id   <= m_axis_rx_tdata[63:48];
                    tag      <= m_axis_rx_tdata[47:40];
                    first_be <= m_axis_rx_tdata[35:32];
                    if (hdr_ok) begin
                        state <= HDR2;
                    end else begin
                        drop_count <= drop_next;
                        state      <= m_axis_rx_tlast ? IDLE : DISCARD;
                    end
                end
                HDR2: if (beat) begin
                    if (!m_axis_rx_tlast) begin
                        drop_count <= drop_next;
                        state      <= DISCARD;
                    end else if (is_wr) begin
                        wr_en   <= 1'b1;
                        wr_addr <= m_axis_rx_tdata[ADDR_WIDTH+1:2];
                        wr_data <= m_axis_rx_tdata[63:32];
                        wr_be   <= first_be;
                        state   <= IDLE;
                    end else begin
                        rd_valid  <= 1'b1;
                        rd_addr   <= m_axis_rx_tdata[ADDR_WIDTH+1:2];
                        rd_req_id <= req_id;
                        rd_tag    <= tag;
                        rd_tc     <= tc;
                        rd_attr   <= attr;
                        state     <= RD_WAIT;
                    end
                end
                DISCARD: if (beat && m_axis_rx_tlast) state <= IDLE;
                RD_WAIT: if (rd_ready) begin
                    rd_valid <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pcie_rx_req_decoder.sv
// tb_pcie_rx_req_decoder: directed checks of the RX request decoder; inputs change
// on the falling edge and outputs are compared there, half a cycle after the active edge.
module tb_pcie_rx_req_decoder;
    logic        user_clk = 1'b0;
    logic        user_reset = 1'b1;
    logic [63:0] m_axis_rx_tdata = '0;
    logic [7:0]  m_axis_rx_tkeep = 8'hFF;
    logic        m_axis_rx_tlast = 1'b0;
    logic        m_axis_rx_tvalid = 1'b0;
    logic        m_axis_rx_tready;
    logic [21:0] m_axis_rx_tuser = '0;
    logic        rx_np_ok;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [9:0]  rd_addr;
    logic [15:0] rd_req_id;
    logic [7:0]  rd_tag;
    logic [2:0]  rd_tc;
    logic [1:0]  rd_attr;
    logic [15:0] drop_count;
    int          total = 0;
    int          bad = 0;

    localparam logic [21:0] BAR0 = 22'h4;

    pcie_rx_req_decoder dut (
        .user_clk(user_clk), .user_reset(user_reset),
        .m_axis_rx_tdata(m_axis_rx_tdata), .m_axis_rx_tkeep(m_axis_rx_tkeep),
        .m_axis_rx_tlast(m_axis_rx_tlast), .m_axis_rx_tvalid(m_axis_rx_tvalid),
        .m_axis_rx_tready(m_axis_rx_tready), .m_axis_rx_tuser(m_axis_rx_tuser),
        .rx_np_ok(rx_np_ok), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rd_req_id(rd_req_id), .rd_tag(rd_tag), .rd_tc(rd_tc), .rd_attr(rd_attr),
        .drop_count(drop_count)
    );

    always #5 user_clk = ~user_clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic logic [63:0] hdr(input logic [6:0] ft, input logic [9:0] len, input logic ep,
                                        input logic [15:0] rid, input logic [7:0] tg, input logic [3:0] be,
                                        input logic [2:0] tcl, input logic [1:0] at);
        return {rid, tg, 4'h0, be, 1'b0, ft, 1'b0, tcl, 5'b0, ep, at, 2'b0, len};
    endfunction

    // Presents one beat from a falling edge and returns on the falling edge after it is taken
    task automatic put(input logic [63:0] d, input logic l, input logic [21:0] u);
        int n = 0;
        m_axis_rx_tdata = d;
        m_axis_rx_tlast = l;
        m_axis_rx_tuser = u;
        m_axis_rx_tvalid = 1'b1;
        while (!m_axis_rx_tready && n < 50) begin
            @(negedge user_clk);
            n++;
        end
        chk("put_tready", m_axis_rx_tready, 1);
        @(negedge user_clk);
        m_axis_rx_tvalid = 1'b0;
    endtask

    task automatic pulse_reset();
        user_reset = 1'b1;
        @(negedge user_clk);
        user_reset = 1'b0;
    endtask

    initial begin
        logic stall_wr;
        repeat (3) @(negedge user_clk);
        user_reset = 1'b0;
        chk("rst_tready", m_axis_rx_tready, 1);
        chk("rst_np_ok", rx_np_ok, 1);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_rd_tag", rd_tag, 0);

        // 1: single-DW write
        put(hdr(7'h40, 10'd1, 1'b0, 16'h0000, 8'h00, 4'hF, 3'd0, 2'd0), 1'b0, BAR0);
        chk("t1_no_early_wr", wr_en, 0);
        put(64'hDEADBEEF_00000010, 1'b1, BAR0);
        chk("t1_wr_en", wr_en, 1);
        chk("t1_wr_addr", wr_addr, 10'h004);
        chk("t1_wr_data", wr_data, 32'hDEADBEEF);
        chk("t1_wr_be", wr_be, 4'hF);
        @(negedge user_clk);
        chk("t1_wr_en_1cyc", wr_en, 0);

        // 2: single-DW read held until rd_ready
        put(hdr(7'h00, 10'd1, 1'b0, 16'h0100, 8'h2A, 4'hF, 3'd2, 2'd1), 1'b0, BAR0);
        put(64'h00000000_00000020, 1'b1, BAR0);
        chk("t2_rd_valid", rd_valid, 1);
        chk("t2_rd_addr", rd_addr, 10'h008);
        chk("t2_rd_tag", rd_tag, 8'h2A);
        chk("t2_rd_req_id", rd_req_id, 16'h0100);
        chk("t2_rd_tc", rd_tc, 3'd2);
        chk("t2_rd_attr", rd_attr, 2'd1);
        chk("t2_tready", m_axis_rx_tready, 0);
        chk("t2_np_ok", rx_np_ok, 0);
        repeat (3) @(negedge user_clk);
        chk("t2_rd_hold", rd_valid, 1);
        chk("t2_rd_addr_hold", rd_addr, 10'h008);
        chk("t2_np_ok_hold", rx_np_ok, 0);
        rd_ready = 1'b1;
        @(negedge user_clk);
        rd_ready = 1'b0;
        chk("t2_rd_done", rd_valid, 0);
        chk("t2_tready_back", m_axis_rx_tready, 1);
        chk("t2_np_ok_back", rx_np_ok, 1);

        // 3: write stalled behind a pending read
        put(hdr(7'h00, 10'd1, 1'b0, 16'h0200, 8'h11, 4'hF, 3'd0, 2'd0), 1'b0, BAR0);
        put(64'h00000000_00000024, 1'b1, BAR0);
        m_axis_rx_tdata = hdr(7'h40, 10'd1, 1'b0, 16'h0, 8'h0, 4'hC, 3'd0, 2'd0);
        m_axis_rx_tlast = 1'b0;
        m_axis_rx_tuser = BAR0;
        m_axis_rx_tvalid = 1'b1;
        stall_wr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge user_clk);
            stall_wr |= wr_en;
        end
        chk("t3_no_wr_in_stall", stall_wr, 0);
        chk("t3_stall_tready", m_axis_rx_tready, 0);
        chk("t3_rd_tag_hold", rd_tag, 8'h11);
        chk("t3_rd_addr", rd_addr, 10'h009);
        rd_ready = 1'b1;
        @(negedge user_clk);
        rd_ready = 1'b0;
        chk("t3_rd_done", rd_valid, 0);
        chk("t3_still_no_wr", wr_en, 0);
        put(hdr(7'h40, 10'd1, 1'b0, 16'h0, 8'h0, 4'hC, 3'd0, 2'd0), 1'b0, BAR0);
        put(64'hCAFEF00D_00000030, 1'b1, BAR0);
        chk("t3_wr_en", wr_en, 1);
        chk("t3_wr_addr", wr_addr, 10'h00C);
        chk("t3_wr_data", wr_data, 32'hCAFEF00D);
        chk("t3_wr_be", wr_be, 4'hC);
        @(negedge user_clk);
        chk("t3_wr_once", wr_en, 0);
        chk("t3_rd_not_again", rd_valid, 0);

        // 4: four rejected TLPs, then a valid write that wraps the address space
        chk("t4_drop0", drop_count, 0);
        put(hdr(7'h40, 10'd2, 1'b0, 16'h0, 8'h0, 4'hF, 3'd0, 2'd0), 1'b0, BAR0);
        put(64'h11111111_00000040, 1'b0, BAR0);
        put(64'h00000000_22222222, 1'b1, BAR0);
        chk("t4_len2_wr", wr_en, 0);
        put(hdr(7'h20, 10'd1, 1'b0, 16'h0, 8'h5, 4'hF, 3'd0, 2'd0), 1'b0, BAR0);
        put(64'h00000050_00000000, 1'b1, BAR0);
        chk("t4_4dw_rd", rd_valid, 0);
        put(hdr(7'h40, 10'd1, 1'b1, 16'h0, 8'h0, 4'hF, 3'd0, 2'd0), 1'b0, BAR0);
        put(64'h33333333_00000060, 1'b1, BAR0);
        chk("t4_ep_wr", wr_en, 0);
        put(hdr(7'h40, 10'd1, 1'b0, 16'h0, 8'h0, 4'hF, 3'd0, 2'd0), 1'b0, 22'h8);
        put(64'h44444444_00000070, 1'b1, 22'h8);
        chk("t4_bar1_wr", wr_en, 0);
        chk("t4_drop4", drop_count, 4);
        put(hdr(7'h40, 10'd1, 1'b0, 16'h0, 8'h0, 4'h3, 3'd0, 2'd0), 1'b0, BAR0);
        put(64'h12345678_00001004, 1'b1, BAR0);
        chk("t4_wr_en", wr_en, 1);
        chk("t4_wr_addr_wrap", wr_addr, 10'h001);
        chk("t4_wr_data", wr_data, 32'h12345678);
        chk("t4_wr_be", wr_be, 4'h3);
        put(hdr(7'h40, 10'd1, 1'b0, 16'h0, 8'h0, 4'hF, 3'd0, 2'd0), 1'b0, BAR0);
        put(64'h55555555_00000080, 1'b0, BAR0);
        put(64'h66666666_66666666, 1'b1, BAR0);
        chk("t4_malformed_wr", wr_en, 0);
        chk("t4_drop5", drop_count, 5);
        put(hdr(7'h40, 10'd1, 1'b0, 16'h0, 8'h0, 4'hF, 3'd0, 2'd0), 1'b0, 22'h6);
        put(64'h77777777_00000090, 1'b1, 22'h6);
        chk("t4_errfwd_wr", wr_en, 0);
        chk("t4_drop6", drop_count, 6);

        // 5: saturation of the drop counter
        for (int i = 0; i < 65528; i++) put(64'h0000000F_7F000001, 1'b1, BAR0);
        chk("t5_drop_fffe", drop_count, 16'hFFFE);
        put(64'h0000000F_7F000001, 1'b1, BAR0);
        chk("t5_drop_ffff", drop_count, 16'hFFFF);
        for (int i = 0; i < 11; i++) put(64'h0000000F_7F000001, 1'b1, BAR0);
        chk("t5_drop_sat", drop_count, 16'hFFFF);

        // 6: reset mid-DISCARD and in RD_WAIT
        put(hdr(7'h40, 10'd3, 1'b0, 16'h0, 8'h0, 4'hF, 3'd0, 2'd0), 1'b0, BAR0);
        put(64'h88888888_000000A0, 1'b0, BAR0);
        pulse_reset();
        chk("t6a_drop_clr", drop_count, 0);
        chk("t6a_tready", m_axis_rx_tready, 1);
        chk("t6a_wr_en", wr_en, 0);
        put(hdr(7'h40, 10'd1, 1'b0, 16'h0, 8'h0, 4'hF, 3'd0, 2'd0), 1'b0, BAR0);
        put(64'hAABBCCDD_000003FC, 1'b1, BAR0);
        chk("t6a_wr_en_after", wr_en, 1);
        chk("t6a_wr_addr", wr_addr, 10'h0FF);
        chk("t6a_wr_data", wr_data, 32'hAABBCCDD);
        put(hdr(7'h00, 10'd1, 1'b0, 16'h0300, 8'h7, 4'hF, 3'd0, 2'd0), 1'b0, BAR0);
        put(64'h00000000_000000B0, 1'b1, BAR0);
        chk("t6b_rd_valid", rd_valid, 1);
        pulse_reset();
        chk("t6b_rd_valid_clr", rd_valid, 0);
        chk("t6b_tready", m_axis_rx_tready, 1);
        chk("t6b_np_ok", rx_np_ok, 1);
        chk("t6b_drop", drop_count, 0);
        put(hdr(7'h40, 10'd1, 1'b0, 16'h0, 8'h0, 4'h1, 3'd0, 2'd0), 1'b0, BAR0);
        put(64'h5555AAAA_00000008, 1'b1, BAR0);
        chk("t6b_wr_en", wr_en, 1);
        chk("t6b_wr_addr", wr_addr, 10'h002);
        chk("t6b_wr_data", wr_data, 32'h5555AAAA);
        chk("t6b_wr_be", wr_be, 4'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
